// File: rtl/zap_cache_line_fill_pkg.sv
// Shared constants, Wishbone control bundle and helpers for the ZAP line-fill engine.
package zap_cache_line_fill_pkg;

    localparam int CACHE_TAG_WDT = 21;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_BURST   = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam int LINE_WORDS = 4;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        wen;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [2:0]  cti;
    } wb_ctl_t;

    function automatic wb_ctl_t wb_idle();
        wb_ctl_t c;
        c     = '0;
        c.cti = CTI_CLASSIC;
        return c;
    endfunction

    // One read beat of the incrementing burst; the last word is flagged end-of-burst.
    function automatic wb_ctl_t wb_read_beat(input logic [31:0] base, input logic [2:0] beat);
        wb_ctl_t c;
        c     = '0;
        c.cyc = 1'b1;
        c.stb = 1'b1;
        c.wen = 1'b0;
        c.sel = 4'b1111;
        c.adr = base + {27'd0, beat, 2'b00};
        c.cti = (beat == 3'd3) ? CTI_EOB : CTI_BURST;
        return c;
    endfunction

endpackage

// File: rtl/zap_cache_line_fill_wdt.sv
// Watchdog for the line-fill engine: counts FILL cycles without a completed beat.
module zap_line_fill_wdt #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_count <= 8'd0;
        end else if (i_count && (r_count != LIMIT)) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/zap_cache_line_fill.sv
// ZAP cache line-fill engine: 4-beat Wishbone burst read assembled into a 128-bit line.
// Optional fill watchdog enabled by defining ZAP_LINE_FILL_TIMEOUT_EN.
module zap_cache_line_fill
    import zap_cache_line_fill_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     i_clk,
    input  logic                     i_reset,

    input  logic                     i_fill_req,
    input  logic [31:0]              i_fill_pa,
    input  logic [CACHE_TAG_WDT-1:0] i_fill_tag,
    output logic                     o_fill_busy,
    output logic                     o_fill_done,
    output logic                     o_fill_err,

    output logic [127:0]             o_cache_line,
    output logic [15:0]              o_cache_line_ben,
    output logic [CACHE_TAG_WDT-1:0] o_cache_tag,
    output logic                     o_cache_tag_wr_en,
    output logic                     o_cache_tag_dirty,

    output logic                     o_wb_cyc_nxt,
    output logic                     o_wb_stb_nxt,
    output logic                     o_wb_wen_nxt,
    output logic [31:0]              o_wb_adr_nxt,
    output logic [3:0]               o_wb_sel_nxt,
    output logic [2:0]               o_wb_cti_nxt,
    output logic                     o_wb_cyc_ff,
    output logic                     o_wb_stb_ff,
    output logic                     o_wb_wen_ff,
    output logic [31:0]              o_wb_adr_ff,
    output logic [3:0]               o_wb_sel_ff,
    output logic [2:0]               o_wb_cti_ff,
    input  logic                     i_wb_ack,
    input  logic [31:0]              i_wb_dat
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;

    logic [1:0]               r_state, w_state_nxt;
    logic [2:0]               r_beat, w_beat_nxt;
    logic [31:0]              r_pa, w_pa_nxt;
    logic [CACHE_TAG_WDT-1:0] r_tag, w_tag_nxt;
    wb_ctl_t                  r_wb, w_wb_nxt;
    logic [31:0]              r_word [LINE_WORDS];
    logic                     w_beat_done;
    logic                     w_timeout;

    // Acks are only meaningful against a strobe we actually issued.
    assign w_beat_done = (r_state == FILL) && i_wb_ack && r_wb.stb;

`ifdef ZAP_LINE_FILL_TIMEOUT_EN
    logic w_wdt_clear;
    logic w_wdt_count;

    assign w_wdt_clear = ((r_state == IDLE) && i_fill_req) || w_beat_done;
    assign w_wdt_count = (r_state == FILL) && !w_beat_done;

    zap_line_fill_wdt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdt (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (w_wdt_clear),
        .i_count   (w_wdt_count),
        .o_expired (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_pa_nxt    = r_pa;
        w_tag_nxt   = r_tag;
        w_wb_nxt    = wb_idle();
        case (r_state)
            IDLE: begin
                if (i_fill_req) begin
                    w_pa_nxt    = {i_fill_pa[31:4], 4'd0};
                    w_tag_nxt   = i_fill_tag;
                    w_beat_nxt  = 3'd0;
                    w_state_nxt = FILL;
                    // First beat goes out on the very next cycle.
                    w_wb_nxt    = wb_read_beat({i_fill_pa[31:4], 4'd0}, 3'd0);
                end
            end
            FILL: begin
                if (w_timeout) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_beat_nxt = r_beat + {2'b00, w_beat_done};
                    if (w_beat_nxt == 3'd4) begin
                        w_state_nxt = WRITE;
                    end else begin
                        w_wb_nxt = wb_read_beat(r_pa, w_beat_nxt);
                    end
                end
            end
            WRITE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_beat  <= 3'd0;
            r_pa    <= 32'd0;
            r_tag   <= '0;
            r_wb    <= wb_idle();
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            r_pa    <= w_pa_nxt;
            r_tag   <= w_tag_nxt;
            r_wb    <= w_wb_nxt;
        end
    end

    generate
        for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_word
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    r_word[gi] <= 32'd0;
                end else if (w_beat_done && (r_beat[1:0] == 2'(gi))) begin
                    r_word[gi] <= i_wb_dat;
                end
            end
            assign o_cache_line[32*gi +: 32] = r_word[gi];
        end
    endgenerate

    assign o_fill_busy       = (r_state != IDLE);
    assign o_fill_done       = (r_state == WRITE) || ((r_state == FILL) && w_timeout);
    assign o_fill_err        = (r_state == FILL) && w_timeout;
    assign o_cache_line_ben  = (r_state == WRITE) ? 16'hFFFF : 16'h0000;
    assign o_cache_tag       = r_tag;
    assign o_cache_tag_wr_en = (r_state == WRITE);
    assign o_cache_tag_dirty = 1'b0;

    assign o_wb_cyc_nxt = w_wb_nxt.cyc;
    assign o_wb_stb_nxt = w_wb_nxt.stb;
    assign o_wb_wen_nxt = w_wb_nxt.wen;
    assign o_wb_adr_nxt = w_wb_nxt.adr;
    assign o_wb_sel_nxt = w_wb_nxt.sel;
    assign o_wb_cti_nxt = w_wb_nxt.cti;
    assign o_wb_cyc_ff  = r_wb.cyc;
    assign o_wb_stb_ff  = r_wb.stb;
    assign o_wb_wen_ff  = r_wb.wen;
    assign o_wb_adr_ff  = r_wb.adr;
    assign o_wb_sel_ff  = r_wb.sel;
    assign o_wb_cti_ff  = r_wb.cti;

endmodule

// File: tb/tb_zap_cache_line_fill.sv
// Directed bench for zap_cache_line_fill with a beat scoreboard and a Wishbone slave model.
module tb_zap_cache_line_fill;
    import zap_cache_line_fill_pkg::*;

`ifdef ZAP_LINE_FILL_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic                     clk = 1'b0;
    logic                     i_reset = 1'b1;
    logic                     i_fill_req = 1'b0;
    logic [31:0]              i_fill_pa = '0;
    logic [CACHE_TAG_WDT-1:0] i_fill_tag = '0;
    logic                     o_fill_busy, o_fill_done, o_fill_err;
    logic [127:0]             o_cache_line;
    logic [15:0]              o_cache_line_ben;
    logic [CACHE_TAG_WDT-1:0] o_cache_tag;
    logic                     o_cache_tag_wr_en, o_cache_tag_dirty;
    logic                     o_wb_cyc_nxt, o_wb_stb_nxt, o_wb_wen_nxt;
    logic [31:0]              o_wb_adr_nxt;
    logic [3:0]               o_wb_sel_nxt;
    logic [2:0]               o_wb_cti_nxt;
    logic                     o_wb_cyc_ff, o_wb_stb_ff, o_wb_wen_ff;
    logic [31:0]              o_wb_adr_ff;
    logic [3:0]               o_wb_sel_ff;
    logic [2:0]               o_wb_cti_ff;
    logic                     i_wb_ack = 1'b0;
    logic [31:0]              i_wb_dat = '0;

    zap_cache_line_fill #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_fill_req(i_fill_req), .i_fill_pa(i_fill_pa), .i_fill_tag(i_fill_tag),
        .o_fill_busy(o_fill_busy), .o_fill_done(o_fill_done), .o_fill_err(o_fill_err),
        .o_cache_line(o_cache_line), .o_cache_line_ben(o_cache_line_ben),
        .o_cache_tag(o_cache_tag), .o_cache_tag_wr_en(o_cache_tag_wr_en),
        .o_cache_tag_dirty(o_cache_tag_dirty),
        .o_wb_cyc_nxt(o_wb_cyc_nxt), .o_wb_stb_nxt(o_wb_stb_nxt), .o_wb_wen_nxt(o_wb_wen_nxt),
        .o_wb_adr_nxt(o_wb_adr_nxt), .o_wb_sel_nxt(o_wb_sel_nxt), .o_wb_cti_nxt(o_wb_cti_nxt),
        .o_wb_cyc_ff(o_wb_cyc_ff), .o_wb_stb_ff(o_wb_stb_ff), .o_wb_wen_ff(o_wb_wen_ff),
        .o_wb_adr_ff(o_wb_adr_ff), .o_wb_sel_ff(o_wb_sel_ff), .o_wb_cti_ff(o_wb_cti_ff),
        .i_wb_ack(i_wb_ack), .i_wb_dat(i_wb_dat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic [2:0]  cti;
        logic [31:0] dat;
    } beat_t;

    beat_t                    sb[$];
    int                       checks = 0;
    int                       failures = 0;
    logic [CACHE_TAG_WDT-1:0] exp_tag = '0;

    task automatic fail(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Called just after a falling edge: that cycle is cycle 0 of the fill.
    task automatic issue(input logic [31:0] pa, input logic [CACHE_TAG_WDT-1:0] tag,
                         input logic [127:0] data);
        beat_t       e;
        logic [31:0] base;
        base = {pa[31:4], 4'd0};
        for (int k = 0; k < 4; k++) begin
            e.adr = base + 32'(4 * k);
            e.cti = (k == 3) ? CTI_EOB : CTI_BURST;
            e.dat = data[32*k +: 32];
            sb.push_back(e);
        end
        i_fill_req = 1'b1;
        i_fill_pa  = pa;
        i_fill_tag = tag;
        exp_tag    = tag;
        $display("issue pa=%08h tag=%0h data=%032h", pa, tag, data);
    endtask

    // Slave model plus checks; rst_after>0 asserts reset once that many beats were acked.
    task automatic service(input int waits, input bit drop_req, input int exp_done,
                           input bit exp_err, input int rst_after);
        int           cycle = 0;
        int           wcnt = 0;
        int           acked = 0;
        int           wr_pulses = 0;
        int           exp_pulses;
        bit           finished = 0;
        bit           aborted = 0;
        logic [127:0] exp_line = '0;
        while (!finished && cycle < 200) begin
            @(negedge clk);
            cycle++;
            if (drop_req) i_fill_req = 1'b0;
            i_wb_ack = 1'b0;
            i_wb_dat = '0;
            if (rst_after > 0 && acked == rst_after) begin
                i_fill_req = 1'b0;
                i_reset = 1'b1;
                @(negedge clk);
                #1;
                checks++; if (o_wb_stb_ff !== 1'b0) fail("rst_stb_ff", o_wb_stb_ff, 1'b0);
                checks++; if (o_wb_cyc_ff !== 1'b0) fail("rst_cyc_ff", o_wb_cyc_ff, 1'b0);
                checks++; if (o_fill_busy !== 1'b0) fail("rst_busy", o_fill_busy, 1'b0);
                checks++; if (o_cache_tag_wr_en !== 1'b0) fail("rst_wr_en", o_cache_tag_wr_en, 1'b0);
                checks++; if (o_cache_line !== 128'd0) fail("rst_line", o_cache_line, 128'd0);
                i_reset = 1'b0;
                sb.delete();
                finished = 1;
                aborted = 1;
                $display("reset after %0d beats, bus idle=%0b", acked, !o_wb_cyc_ff);
            end else begin
                #1;
                if (o_cache_tag_wr_en) wr_pulses++;
                if (o_fill_done) begin
                    finished = 1;
                    checks++; if (cycle !== exp_done) fail("done_cycle", cycle, exp_done);
                    checks++; if (o_fill_err !== exp_err) fail("fill_err", o_fill_err, exp_err);
                    checks++; if (o_cache_tag_dirty !== 1'b0) fail("dirty", o_cache_tag_dirty, 1'b0);
                    if (exp_err) begin
                        checks++; if (o_cache_tag_wr_en !== 1'b0) fail("err_wr_en", o_cache_tag_wr_en, 1'b0);
                        sb.delete();
                    end else begin
                        checks++; if (o_cache_line !== exp_line) fail("line", o_cache_line, exp_line);
                        checks++; if (o_cache_line_ben !== 16'hFFFF) fail("ben", o_cache_line_ben, 16'hFFFF);
                        checks++; if (o_cache_tag_wr_en !== 1'b1) fail("wr_en", o_cache_tag_wr_en, 1'b1);
                        checks++; if (o_cache_tag !== exp_tag) fail("tag", o_cache_tag, exp_tag);
                        checks++; if (o_wb_cyc_ff !== 1'b0) fail("cyc_ff_done", o_wb_cyc_ff, 1'b0);
                    end
                    $display("done cycle=%0d err=%0b line=%032h", cycle, o_fill_err, o_cache_line);
                end else if (o_wb_stb_ff && sb.size() > 0) begin
                    checks++; if (o_wb_adr_ff !== sb[0].adr) fail("adr", o_wb_adr_ff, sb[0].adr);
                    checks++; if (o_wb_cti_ff !== sb[0].cti) fail("cti", o_wb_cti_ff, sb[0].cti);
                    checks++; if (o_wb_sel_ff !== 4'hF) fail("sel", o_wb_sel_ff, 4'hF);
                    checks++; if (o_wb_wen_ff !== 1'b0) fail("wen", o_wb_wen_ff, 1'b0);
                    if (wcnt == waits) begin
                        i_wb_ack = 1'b1;
                        i_wb_dat = sb[0].dat;
                        exp_line[32*acked +: 32] = sb[0].dat;
                        $display("beat %0d adr=%08h cti=%03b dat=%08h", acked, sb[0].adr, sb[0].cti, sb[0].dat);
                        void'(sb.pop_front());
                        acked++;
                        wcnt = 0;
                    end else begin
                        wcnt++;
                    end
                end
            end
        end
        checks++; if (finished !== 1'b1) fail("fill_finished", finished, 1'b1);
        if (!aborted) begin
            @(negedge clk);
            #1;
            checks++; if (o_cache_tag_wr_en !== 1'b0) fail("post_wr_en", o_cache_tag_wr_en, 1'b0);
            checks++; if (o_fill_done !== 1'b0) fail("post_done", o_fill_done, 1'b0);
            checks++; if (o_cache_line_ben !== 16'h0000) fail("post_ben", o_cache_line_ben, 16'h0000);
            checks++; if (o_wb_stb_ff !== 1'b0) fail("post_stb_ff", o_wb_stb_ff, 1'b0);
        end
        exp_pulses = (aborted || exp_err) ? 0 : 1;
        checks++; if (wr_pulses !== exp_pulses) fail("wr_pulses", wr_pulses, exp_pulses);
    endtask

    initial begin
        logic [127:0] d;
        repeat (3) @(negedge clk);
        i_reset = 1'b0;
        #1;
        checks++; if (o_fill_busy !== 1'b0) fail("rst_state_busy", o_fill_busy, 1'b0);
        checks++; if (o_wb_stb_ff !== 1'b0) fail("rst_stb", o_wb_stb_ff, 1'b0);
        checks++; if (o_wb_cyc_ff !== 1'b0) fail("rst_cyc", o_wb_cyc_ff, 1'b0);
        checks++; if (o_wb_adr_ff !== 32'd0) fail("rst_adr", o_wb_adr_ff, 32'd0);
        checks++; if (o_wb_cti_ff !== CTI_CLASSIC) fail("rst_cti", o_wb_cti_ff, CTI_CLASSIC);
        checks++; if (o_cache_line !== 128'd0) fail("rst_line0", o_cache_line, 128'd0);
        checks++; if (o_cache_tag !== '0) fail("rst_tag", o_cache_tag, 0);
        checks++; if (o_fill_done !== 1'b0) fail("rst_done", o_fill_done, 1'b0);
        checks++; if (o_fill_err !== 1'b0) fail("rst_err", o_fill_err, 1'b0);
        checks++; if (o_cache_line_ben !== 16'h0000) fail("rst_ben", o_cache_line_ben, 16'h0000);

        // Zero-wait fill
        @(negedge clk);
        issue(32'h0000_1230, 21'h1ABCD, 128'h44444444_33333333_22222222_11111111);
        service(0, 1, 5, 0, 0);
        checks++;
        if (o_cache_line !== 128'h44444444_33333333_22222222_11111111)
            fail("line_hold", o_cache_line, 128'h44444444_33333333_22222222_11111111);

        // Two wait states per beat
        @(negedge clk);
        d = {$urandom, $urandom, $urandom, $urandom};
        issue(32'h8000_0040, 21'h00F0F, d);
        service(2, 1, 13, 0, 0);

        // Low address bits ignored
        @(negedge clk);
        d = {$urandom, $urandom, $urandom, $urandom};
        issue(32'h0000_100F, 21'h12345, d);
        service(0, 1, 5, 0, 0);

        // Request held through fill: one write, then back-to-back fill
        @(negedge clk);
        d = {$urandom, $urandom, $urandom, $urandom};
        issue(32'h0000_2000, 21'h0AAAA, d);
        service(0, 0, 5, 0, 0);
        checks++; if (o_fill_busy !== 1'b0) fail("hold_idle_busy", o_fill_busy, 1'b0);
        d = {$urandom, $urandom, $urandom, $urandom};
        issue(32'h0000_2000, 21'h0AAAA, d);
        service(0, 1, 5, 0, 0);

        // Reset mid-burst, then a clean fill
        @(negedge clk);
        d = {$urandom, $urandom, $urandom, $urandom};
        issue(32'h0000_3000, 21'h05555, d);
        service(0, 1, 0, 0, 2);
        @(negedge clk);
        d = {$urandom, $urandom, $urandom, $urandom};
        issue(32'hFFFF_FFF0, 21'h1FFFF, d);
        service(0, 1, 5, 0, 0);

`ifdef ZAP_LINE_FILL_TIMEOUT_EN
        // Silent slave: watchdog aborts
        @(negedge clk);
        d = {$urandom, $urandom, $urandom, $urandom};
        issue(32'h0000_4000, 21'h00001, d);
        service(100000, 1, 9, 1, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
